// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole controller: FSM states,
// board size, score ceiling, LFSR step and hole selection.
package mole_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SHOW,
    ST_GAP,
    ST_OVER
  } state_e;

  localparam int         N_HOLES   = 5;
  localparam logic [6:0] SCORE_MAX = 7'd99;
  // Fibonacci taps 8,6,5,4 expressed as a bit mask on lfsr[7:0]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  localparam logic [2:0] HOLE_NONE = 3'd7;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // Fold 0..7 onto 0..4, then step past the previous hole so a mole never repeats.
  function automatic logic [2:0] hole_pick(input logic [2:0] raw, input logic [2:0] prev);
    logic [2:0] h;
    h = (raw >= 3'd5) ? raw - 3'd5 : raw;
    if (h == prev) h = (h == 3'd4) ? 3'd0 : h + 3'd1;
    return h;
  endfunction

  function automatic logic [N_HOLES-1:0] hole_led(input logic [2:0] h);
    return {{(N_HOLES-1){1'b0}}, 1'b1} << h;
  endfunction

endpackage

// File: rtl/mole_scheduler_tick_gen.sv
// Game tick source: one-cycle pulse every DIV clocks; clr restarts the period.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr || r_cnt == CW'(DIV - 1)) r_cnt <= '0;
    else                                        r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round controller: switch edge detect, LFSR mole placement,
// hit windows, scoring and the round countdown.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int         TICK_DIV   = 5_000_000,
  parameter int         GAME_TICKS = 150,
  parameter int         MOLE_TICKS = 10,
  parameter int         GAP_TICKS  = 2,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_HOLES-1:0] sw,
  output logic [N_HOLES-1:0] led,
  output logic [6:0]         score,
  output logic [7:0]         time_left,
  output logic               busy,
  output logic               game_over,
  output logic               hit,
  output logic               miss
);

  logic [N_HOLES-1:0] r_sw_meta, r_sw_sync, r_sw_dly, r_edge;
  logic [7:0]         r_lfsr;
  state_e             r_state;
  logic [2:0]         r_hole;
  logic [7:0]         r_mole_cnt, r_gap_cnt;
  logic               r_missed;
  logic [N_HOLES-1:0] r_led;
  logic [6:0]         r_score;
  logic [7:0]         r_time;
  logic               r_busy, r_over, r_hit, r_miss;

  logic               w_tick, w_clr, w_last_tick, w_hit_edge, w_wrong_edge;
  logic [2:0]         w_hole;

  // NOTE: r_sw_meta may go metastable; only r_sw_sync ever samples it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_sw_dly  <= '0;
      r_edge    <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_sw_dly  <= r_sw_sync;
      r_edge    <= r_sw_sync & ~r_sw_dly;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_clr        = (r_state == ST_IDLE || r_state == ST_OVER) && start;
  assign w_last_tick  = w_tick && (r_time == 8'd1);
  assign w_hole       = hole_pick(r_lfsr[2:0], r_hole);
  assign w_hit_edge   = |(r_edge & r_led);
  assign w_wrong_edge = |(r_edge & ~r_led);

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_hole     <= HOLE_NONE;
      r_mole_cnt <= '0;
      r_gap_cnt  <= '0;
      r_missed   <= 1'b0;
      r_led      <= '0;
      r_score    <= '0;
      r_time     <= '0;
      r_busy     <= 1'b0;
      r_over     <= 1'b0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
    end else begin
      // NOTE: pulses default low here; a later non-blocking write in this block overrides it.
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            r_score <= '0;
            r_time  <= 8'(GAME_TICKS);
            r_busy  <= 1'b1;
            r_over  <= 1'b0;
            r_state <= ST_ARM;
          end
        end
        default: begin
          if (w_tick) r_time <= r_time - 8'd1;
          // Round end beats any hit or miss judged in the same cycle.
          if (w_last_tick) begin
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_over  <= 1'b1;
            r_state <= ST_OVER;
          end else begin
            case (r_state)
              ST_ARM: begin
                r_hole     <= w_hole;
                r_led      <= hole_led(w_hole);
                r_mole_cnt <= 8'(MOLE_TICKS);
                r_missed   <= 1'b0;
                r_state    <= ST_SHOW;
              end
              ST_SHOW: begin
                if (w_hit_edge) begin
                  r_hit     <= 1'b1;
                  r_score   <= (r_score >= SCORE_MAX) ? SCORE_MAX : r_score + 7'd1;
                  r_led     <= '0;
                  r_gap_cnt <= 8'(GAP_TICKS);
                  r_state   <= ST_GAP;
                end else if (w_tick && r_mole_cnt == 8'd1) begin
                  r_miss    <= 1'b1;
                  r_led     <= '0;
                  r_gap_cnt <= 8'(GAP_TICKS);
                  r_state   <= ST_GAP;
                end else begin
                  if (w_tick) r_mole_cnt <= r_mole_cnt - 8'd1;
                  if (w_wrong_edge && !r_missed) begin
                    r_miss   <= 1'b1;
                    r_missed <= 1'b1;
                  end
                end
              end
              ST_GAP: begin
                if (w_tick) begin
                  if (r_gap_cnt == 8'd1) r_state <= ST_ARM;
                  else                   r_gap_cnt <= r_gap_cnt - 8'd1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign led       = r_led;
  assign score     = r_score;
  assign time_left = r_time;
  assign busy      = r_busy;
  assign game_over = r_over;
  assign hit       = r_hit;
  assign miss      = r_miss;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler: scripted rounds from a vector table,
// reset abort, start-while-busy, placement statistics and score saturation.
`timescale 1ns/1ps
module tb_mole_scheduler;

  localparam int TD = 4;
  localparam int GT = 20;
  localparam int MT = 3;
  localparam int GP = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] sw = '0;
  logic [4:0] led;
  logic [6:0] score;
  logic [7:0] time_left;
  logic       busy, game_over, hit, miss;

  logic       start2 = 1'b0;
  logic [4:0] sw2 = '0;
  logic [4:0] led2;
  logic [6:0] score2;
  logic [7:0] time_left2;
  logic       busy2, game_over2, hit2, miss2;

  always #5 clk = ~clk;

  mole_scheduler #(
    .TICK_DIV(TD), .GAME_TICKS(GT), .MOLE_TICKS(MT), .GAP_TICKS(GP), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sw(sw), .led(led), .score(score),
    .time_left(time_left), .busy(busy), .game_over(game_over), .hit(hit), .miss(miss)
  );

  // Long-round instance, used only to reach the score ceiling.
  mole_scheduler #(
    .TICK_DIV(8), .GAME_TICKS(255), .MOLE_TICKS(10), .GAP_TICKS(1), .LFSR_SEED(8'hA5)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .sw(sw2), .led(led2), .score(score2),
    .time_left(time_left2), .busy(busy2), .game_over(game_over2), .hit(hit2), .miss(miss2)
  );

  typedef enum {A_NONE, A_RIGHT, A_WRONG1, A_WRONG2, A_BOTH, A_START, A_RELEASE} act_e;

  typedef struct {
    int         rnd;
    int         cyc;
    act_e       act;
    logic       hit;
    logic       miss;
    logic [6:0] score;
    logic       lit;
    logic       over;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   hist[5];
  int   n_moles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input int rnd, input int cyc, input act_e act, input logic h,
                     input logic m, input logic [6:0] s, input logic lit, input logic ov);
    vec_t v;
    v.rnd = rnd; v.cyc = cyc; v.act = act; v.hit = h; v.miss = m;
    v.score = s; v.lit = lit; v.over = ov;
    vecs.push_back(v);
  endtask

  function automatic logic [4:0] rot5(input logic [4:0] v, input int n);
    logic [4:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[3:0], r[4]};
    return r;
  endfunction

  // Called at a negedge; returns at the negedge right after start was sampled (k=0).
  task automatic start_round();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_table(input int rnd);
    int k;
    k = 0;
    start_round();
    foreach (vecs[i]) begin
      if (vecs[i].rnd == rnd) begin
        while (k < vecs[i].cyc) begin
          step();
          start = 1'b0;
          k++;
        end
        check($sformatf("r%0d k%0d hit", rnd, k), hit, vecs[i].hit);
        check($sformatf("r%0d k%0d miss", rnd, k), miss, vecs[i].miss);
        check($sformatf("r%0d k%0d score", rnd, k), score, vecs[i].score);
        check($sformatf("r%0d k%0d lit", rnd, k), led != 5'd0, vecs[i].lit);
        check($sformatf("r%0d k%0d onehot0", rnd, k), $onehot0(led), 1);
        check($sformatf("r%0d k%0d over", rnd, k), game_over, vecs[i].over);
        check($sformatf("r%0d k%0d busy", rnd, k), busy, !vecs[i].over);
        check($sformatf("r%0d k%0d time", rnd, k), time_left, GT - k / TD);
        case (vecs[i].act)
          A_RIGHT:   sw = sw | led;
          A_WRONG1:  sw = sw | rot5(led, 1);
          A_WRONG2:  sw = sw | rot5(led, 2);
          A_BOTH:    sw = sw | led | rot5(led, 1);
          A_START:   start = 1'b1;
          A_RELEASE: sw = '0;
          default:   ;
        endcase
      end
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_over(input string name, input int bound);
    int n;
    n = 0;
    while (!game_over && n < bound) begin
      step();
      n++;
    end
    check(name, game_over, 1);
  endtask

  task automatic random_moles();
    int         prev;
    int         h;
    int         guard;
    logic [4:0] last_led;
    prev = -1;
    for (int rnd = 0; rnd < 60 && n_moles < 200; rnd++) begin
      step($urandom_range(0, 15));
      start_round();
      last_led = '0;
      guard = 0;
      while (!game_over && guard < 120) begin
        if (led != 5'd0 && last_led == 5'd0) begin
          h = -1;
          for (int b = 0; b < 5; b++) if (led[b]) h = b;
          check("rand onehot", $onehot(led), 1);
          check("rand repeat", h == prev, 0);
          if (h >= 0) hist[h]++;
          prev = h;
          n_moles++;
        end
        last_led = led;
        step();
        guard++;
      end
      check("rand round end", game_over, 1);
    end
    check("rand mole count", n_moles >= 200, 1);
    for (int b = 0; b < 5; b++) check($sformatf("rand hole %0d seen", b), hist[b] >= 10, 1);
  endtask

  task automatic saturate();
    int         n_hit;
    int         n_miss;
    int         guard;
    logic [6:0] exp;
    n_hit = 0; n_miss = 0; guard = 0; exp = '0;
    start2 = 1'b1;
    while (n_hit < 101 && !game_over2 && guard < 3000) begin
      step();
      start2 = 1'b0;
      guard++;
      if (hit2) begin
        n_hit++;
        exp = (exp == 7'd99) ? 7'd99 : exp + 7'd1;
        check($sformatf("sat score after hit %0d", n_hit), score2, exp);
      end
      if (miss2) n_miss++;
      sw2 = led2;
    end
    check("sat hit count", n_hit, 101);
    check("sat miss count", n_miss, 0);
    check("sat final score", score2, 99);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round 0: early hit, one timeout, correct edge landing on the final tick.
    add(0,  0, A_NONE,    0, 0, 0, 0, 0);
    add(0,  1, A_RIGHT,   0, 0, 0, 1, 0);
    add(0,  4, A_NONE,    0, 0, 0, 1, 0);
    add(0,  5, A_RELEASE, 1, 0, 1, 0, 0);
    add(0,  6, A_NONE,    0, 0, 1, 0, 0);
    add(0,  9, A_NONE,    0, 0, 1, 1, 0);
    add(0, 19, A_NONE,    0, 0, 1, 1, 0);
    add(0, 20, A_NONE,    0, 1, 1, 0, 0);
    add(0, 73, A_NONE,    0, 0, 1, 1, 0);
    add(0, 76, A_RIGHT,   0, 0, 1, 1, 0);
    add(0, 79, A_NONE,    0, 0, 1, 1, 0);
    add(0, 80, A_RELEASE, 0, 0, 1, 0, 1);
    // Round 1: two wrong presses, start while busy, right press, correct+wrong together.
    add(1,  0, A_NONE,    0, 0, 0, 0, 0);
    add(1,  1, A_WRONG1,  0, 0, 0, 1, 0);
    add(1,  2, A_WRONG2,  0, 0, 0, 1, 0);
    add(1,  3, A_START,   0, 0, 0, 1, 0);
    add(1,  4, A_NONE,    0, 0, 0, 1, 0);
    add(1,  5, A_NONE,    0, 1, 0, 1, 0);
    add(1,  6, A_RIGHT,   0, 0, 0, 1, 0);
    add(1,  9, A_NONE,    0, 0, 0, 1, 0);
    add(1, 10, A_RELEASE, 1, 0, 1, 0, 0);
    add(1, 13, A_BOTH,    0, 0, 1, 1, 0);
    add(1, 16, A_NONE,    0, 0, 1, 1, 0);
    add(1, 17, A_RELEASE, 1, 0, 2, 0, 0);
    add(1, 18, A_NONE,    0, 0, 2, 0, 0);

    reset = 1'b0;
    step(3);
    check("reset led", led, 0);
    check("reset score", score, 0);
    check("reset time", time_left, 0);
    check("reset busy", busy, 0);
    check("reset over", game_over, 0);
    check("reset pulses", {hit, miss}, 0);
    reset = 1'b1;
    step(2);
    check("idle busy", busy, 0);
    check("idle led", led, 0);

    run_table(0);
    run_table(1);
    wait_over("r1 over", 100);
    check("r1 final score", score, 2);
    check("r1 final time", time_left, 0);

    // Reset in the middle of a mole window, with a wrong press in flight.
    start_round();
    step();
    check("rst lit", $onehot(led), 1);
    sw = rot5(led, 1);
    step();
    reset = 1'b0;
    step();
    check("rst led", led, 0);
    check("rst score", score, 0);
    check("rst time", time_left, 0);
    check("rst busy", busy, 0);
    check("rst over", game_over, 0);
    check("rst pulses", {hit, miss}, 0);
    reset = 1'b1;
    sw = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rst quiet %0d", i), {hit, miss, busy, led}, 0);
    end

    random_moles();
    saturate();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game controller for the whack-a-mole board: runs one timed round, picks mole positions pseudo-randomly, opens a hit window per mole, judges switch presses, and keeps score and remaining time. It sits between the board switches/LEDs and the seven-segment display path. It replaces the fixed-sequence game FSM and the free-running countdown with one sequenced, start-triggered controller.

## Interface
Parameters:
- TICK_DIV, 5_000_000: clk cycles per game tick (100 ms at 50 MHz)
- GAME_TICKS, 150: round length in ticks (≤255)
- MOLE_TICKS, 10: hit window per mole in ticks (≥1)
- GAP_TICKS, 2: dark interval between moles in ticks (≥1)
- LFSR_SEED, 8'hA5: LFSR reset value (non-zero)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  level; high for ≥1 cycle starts a round from IDLE or OVER
- sw  in  5  raw board switches, asynchronous
- led  out  5  one-hot active mole, or 0
- score  out  7  hits this round, 0..99
- time_left  out  8  remaining ticks
- busy  out  1  high in ARM/SHOW/GAP
- game_over  out  1  high in OVER
- hit  out  1  one-cycle pulse, correct press
- miss  out  1  one-cycle pulse, wrong press or window expiry

## Operation
- sw passes through a 2-flop synchronizer, then a delay register. edge = sync & ~delayed, one cycle per rising edge.
- 8-bit Fibonacci LFSR, taps 8,6,5,4. It advances every cycle, including IDLE, so position depends on start timing.
- States:
  - IDLE: all outputs 0. If start, then score←0, time_left←GAME_TICKS, tick divider cleared, go to ARM.
  - ARM (1 cycle): hole = lfsr[2:0] mod 5 (5,6,7→0,1,2). If hole equals the previous hole, hole←(hole+1) mod 5. mole_cnt←MOLE_TICKS. Go to SHOW.
  - SHOW: led = 1<<hole.
    - edge[hole] → hit, score+1 saturating at 99, go to GAP.
    - else any edge[other] → miss, stay in SHOW. Further wrong edges in the same window do not pulse again.
    - else on tick with mole_cnt==1 → miss, go to GAP. Otherwise each tick decrements mole_cnt.
  - GAP: led=0. Go to ARM after GAP_TICKS ticks.
  - OVER: led=0, score and time_left held, game_over=1. If start, begin a new round as from IDLE.
- time_left decrements on every tick in ARM/SHOW/GAP. On the tick where it reaches 0, go to OVER from any state. This has priority over a hit or miss in that cycle: no pulse, and score is not updated.
- A correct and a wrong edge in the same cycle count as a hit only.
- start while busy is ignored.
- Previous hole resets to 7 (none), so the first mole is never adjusted.

## Timing
- Reset (reset==0 at posedge): state IDLE, lfsr=LFSR_SEED, synchronizer/delay 0, all outputs 0. Reset mid-round aborts with no pulses.
- All outputs are registered.
- Sw pin rise to edge: 3 cycles. Edge to hit/miss pulse and score update: 1 cycle.
- start sampled high at cycle t: busy=1 and time_left=GAME_TICKS at t+1. ARM runs at t+1, led valid at t+2.
- Tick divider: the first tick is TICK_DIV cycles after start is accepted, then every TICK_DIV cycles.
- Total round = GAME_TICKS×TICK_DIV cycles ±1.

## Structure
- Shared package mole_pkg holds:
  - state enum (IDLE, ARM, SHOW, GAP, OVER)
  - N_HOLES=5, SCORE_MAX=99, LFSR taps
- One sub-module, tick_gen (param DIV; in clk, reset, clr; out tick), gives a 1-cycle pulse every DIV cycles. clr zeroes its counter.
- Synchronizer, LFSR and FSM are inline.

## Test plan
All tests use TICK_DIV=4, GAME_TICKS=20, MOLE_TICKS=3, GAP_TICKS=1.
- Reset then start pulse → busy=1, time_left=20 next cycle; led one-hot 1 cycle later; game_over=1 after 80±1 cycles with time_left=0.
- Press the lit switch during SHOW → hit pulses exactly once, 4 cycles after the pin rise; score 0→1; led=0 next cycle.
- Press a wrong switch, then the right one → one miss pulse, then hit; score=1. No press → miss after 12 cycles of SHOW, score unchanged.
- Press the correct and a wrong switch in the same cycle → hit only; score increments. Force score=99 and hit → score stays 99.
- Correct edge on the final tick cycle → OVER, no hit, score unchanged. Assert reset mid-SHOW → all outputs 0, IDLE, no pulses.
- 200 moles with random start timing → consecutive holes never equal, every led value one-hot within 0..4, each hole seen ≥10 times.
